// File: rtl/wb_spi_mem.sv
// Wishbone slave mapping word accesses onto a serial SPI memory.
// One SPI frame per request: opcode, address, then data bytes.
module wb_spi_mem #(
  parameter int          ADR_BYTES = 3,
  parameter logic [7:0]  CMD_RD    = 8'h03,
  parameter logic [7:0]  CMD_WR    = 8'h02
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_wb_adr,
  input  logic [31:0] i_wb_dat,
  input  logic [3:0]  i_wb_sel,
  input  logic        i_wb_we,
  input  logic        i_wb_cyc,
  output logic [31:0] o_wb_rdt,
  output logic        o_wb_ack,
  output logic        o_spi_sck,
  output logic        o_spi_cs_n,
  output logic        o_spi_mosi,
  input  logic        i_spi_miso
);

  localparam int AW = 8 * ADR_BYTES;
  localparam int TW = 8 + AW + 32;

  typedef enum logic [2:0] {
    IDLE, CMD, ADDR, DATA, DONE
  } state_t;

  state_t        state;
  logic [TW-1:0] tx;
  logic [31:0]   rx;
  logic [31:0]   rx_nxt;
  logic [7:0]    cnt;
  logic [7:0]    term;
  logic [2:0]    nbytes;
  logic          we;
  logic          skip;
  logic          started;
  logic          last_bit;

  logic [1:0]    lo;
  logic [1:0]    hi;
  logic [31:0]   dsh;
  logic [31:0]   dfield;
  logic [AW-1:0] adr_f;
  logic [7:0]    opc;
  logic          unused_adr;

  assign unused_adr = ^{i_wb_adr >> AW, i_wb_adr[1:0]};

  function automatic logic [31:0] bswap(
    input logic [31:0] v
  );
    return {v[7:0], v[15:8], v[23:16], v[31:24]};
  endfunction

  always_comb begin
    lo = 2'd0;
    hi = 2'd0;
    for (int k = 3; k >= 0; k--)
      if (i_wb_sel[k]) lo = 2'(k);
    for (int k = 0; k < 4; k++)
      if (i_wb_sel[k]) hi = 2'(k);
  end

  // Start lane moves to the top byte so lanes go out in ascending order.
  assign dsh    = i_wb_dat >> {lo, 3'b000};
  assign dfield = i_wb_we ? bswap(dsh) : 32'h0;
  assign adr_f  = {i_wb_adr[AW-1:2],
                   i_wb_we ? lo : 2'b00};
  assign opc    = i_wb_we ? CMD_WR : CMD_RD;
  assign rx_nxt = {rx[30:0], i_spi_miso};

  always_comb begin
    term = 8'd8;
    case (state)
      ADDR:    term = 8'(AW);
      DATA:    term = 8'({nbytes, 3'b000});
      default: term = 8'd8;
    endcase
  end

  assign last_bit = (cnt == term - 8'd1);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= IDLE;
      o_spi_cs_n <= 1'b1;
      o_spi_sck  <= 1'b0;
      o_spi_mosi <= 1'b0;
      o_wb_ack   <= 1'b0;
      o_wb_rdt   <= 32'h0;
      tx         <= '0;
      rx         <= '0;
      cnt        <= '0;
      nbytes     <= '0;
      we         <= 1'b0;
      skip       <= 1'b0;
      started    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          o_wb_ack <= 1'b0;
          if (i_wb_cyc && !o_wb_ack) begin
            state   <= CMD;
            we      <= i_wb_we;
            skip    <= i_wb_we && (i_wb_sel == 4'b0);
            nbytes  <= i_wb_we ?
                       3'(hi) - 3'(lo) + 3'd1 :
                       3'd4;
            tx      <= {opc, adr_f, dfield};
            cnt     <= '0;
            started <= 1'b0;
          end
        end
        CMD, ADDR, DATA: begin
          if (!started) begin
            started <= 1'b1;
            if (!skip) begin
              o_spi_cs_n <= 1'b0;
              o_spi_sck  <= 1'b0;
              o_spi_mosi <= tx[TW-1];
              tx         <= tx << 1;
            end
          end else if (skip) begin
            state    <= DONE;
            o_wb_ack <= 1'b1;
          end else if (!o_spi_sck) begin
            o_spi_sck <= 1'b1;
          end else begin
            rx  <= rx_nxt;
            cnt <= last_bit ? 8'd0 : cnt + 8'd1;
            if (last_bit && state == DATA) begin
              state      <= DONE;
              o_spi_cs_n <= 1'b1;
              o_spi_sck  <= 1'b0;
              o_spi_mosi <= 1'b0;
              o_wb_ack   <= 1'b1;
              if (!we) o_wb_rdt <= bswap(rx_nxt);
            end else begin
              if (last_bit)
                state <= (state == CMD) ? ADDR : DATA;
              o_spi_sck  <= 1'b0;
              o_spi_mosi <= tx[TW-1];
              tx         <= tx << 1;
            end
          end
        end
        DONE: begin
          state    <= IDLE;
          o_wb_ack <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
